morse_letter_sequencer: RTL and testbench
=========================================

# morse_letter_sequencer

Controller that sequences the 12-bit rotating Morse shift register for one letter (A–H) per request. It owns the Morse pattern table, the half-second element timer and the load/shift handshake to the register, and gates the register's serial bit onto the display LED. Sits between the board switches/keys and the rotating register.

## Interface
- `TICK_DIV`, 25_000_000: clock cycles per Morse element (0.5 s at 50 MHz); must be ≥ 2.
- `PAT_W`, 12: pattern width, i.e. the register width and the elements per frame.

- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces the idle state.
- `start`  in  1  request; sampled only in IDLE.
- `letter`  in  3  0=A … 7=H; latched when `start` is accepted.
- `q_lsb`  in  1  bit 0 of the rotating register's output.
- `pattern`  out  PAT_W  parallel data for the register's load port.
- `load_n`  out  1  active-low parallel-load strobe to the register.
- `shift_en`  out  1  one-cycle shift enable to the register.
- `led`  out  1  display bit, equal to `q_lsb & busy_shift`.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Dot = 1 element on. Dash = 3 elements on. 1 element off between symbols. Bits are sent LSB first.
- Pattern ROM (hex): A 01D, B 157, C 5D7, D 057, E 001, F 175, G 177, H 055. Unused upper bits are 0.
- State IDLE:
  - `load_n`=1, `shift_en`=0, `busy`=0, `led`=0.
  - `start`=1 latches `letter` and moves to LOAD.
- State LOAD:
  - Lasts exactly one cycle. `load_n`=0, `pattern`=ROM[latched letter], `busy`=1.
  - Clears the tick counter and the bit counter. Moves to SHIFT.
- State SHIFT (`busy_shift`=1):
  - The tick counter counts 0..TICK_DIV-1.
  - At terminal count: `shift_en`=1 for that one cycle and the bit counter increments.
  - When the bit counter reaches PAT_W, move to DONE.
- State DONE:
  - One cycle. `done`=1, `busy` stays 1. Moves to IDLE, or to GAP if repeat is enabled (see Configuration).
- `pattern` holds the latched ROM word in every state. The ROM uses combinational lookup of the latched index.
- `start` outside IDLE is ignored; it is not queued.
- `letter` changes after acceptance have no effect.

## Timing
- Reset values: `load_n`=1, `shift_en`=0, `busy`=0, `done`=0, `led`=0, state IDLE, both counters 0, latched letter 0.
- `start` high in cycle N → `load_n` low in cycle N+1 → SHIFT from N+2.
- Each element is visible on `led` for exactly TICK_DIV cycles. The first element lasts a full TICK_DIV, because the counter is cleared in LOAD.
- A frame is PAT_W·TICK_DIV cycles in SHIFT. `done` is asserted in cycle N+2+PAT_W·TICK_DIV.
- `busy` is high for PAT_W·TICK_DIV+2 cycles.
- A new `start` can be accepted in the cycle after `done`.
- `reset` mid-frame:
  - All outputs return to their reset values immediately, with no `done` pulse.
  - The register contents are not cleared by this block, but `led` is masked.
- The tick counter width is `$clog2(TICK_DIV)`. The bit counter width is `$clog2(PAT_W+1)`. There is no wrap inside a frame.

## Configuration
- `MORSE_REPEAT_EN` defined:
  - Adds input `repeat` (1 bit) and state GAP.
  - If `repeat`=1 in DONE, go to GAP for 3·TICK_DIV cycles (`led`=0, `busy`=1), then LOAD with the same latched letter.
  - `repeat`=0 in DONE returns to IDLE.
  - `done` still pulses once per frame.
- `MORSE_REPEAT_EN` undefined: there is no `repeat` port and no GAP state; DONE always returns to IDLE.

## Structure
- Shared package `morse_pkg`:
  - State enum (IDLE, LOAD, SHIFT, DONE, GAP).
  - `PAT_W` default.
  - The 8-entry pattern ROM constant.
  - The `GAP_TICKS`=3 constant.
- One sub-module: `morse_tick_gen`, the element-rate divider. Inputs: `clock`, `reset`, `clear`, `run`. Output: `tick`, a terminal-count pulse.
- FSM, bit counter and output logic live in the top module.

## Test plan
Benches use TICK_DIV=4.
- Reset, then idle 20 cycles → all outputs at reset values; no `load_n` pulse.
- `start`=1, `letter`=0 (A) in cycle 5 → `load_n`=0 in cycle 6 only; `pattern`=0x01D. With a model register, `led` reads 1,0,1,1,1 then 0s, each held 4 cycles; `done` in cycle 55.
- `letter`=4 (E) → exactly one `led` high element; 12 `shift_en` pulses spaced 4 cycles apart; `busy` high 50 cycles.
- `start` pulsed again mid-frame with `letter`=7 → ignored: `pattern` stays the original word; one `done`.
- Assert `reset` at cycle 20 of a C frame → next cycle IDLE, `busy`=0, `led`=0, no `done`. A following `start` (C) runs a full frame with `pattern`=0x5D7.
- With `MORSE_REPEAT_EN` and `repeat`=1, letter G → `done` pulses, 12 idle cycles (GAP), reload 0x177, second `done`. Dropping `repeat` before the second DONE → IDLE.

Source files
------------

// File: rtl/morse_letter_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and constants for the Morse letter sequencer:
//                FSM state encoding, default pattern width, the 8-entry
//                letter pattern ROM (A..H) and the inter-frame gap length.
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

    // Sequencer states; GAP is only reachable when repeat mode is built in.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int PAT_W_DEFAULT = 12;
    localparam int ROM_W         = 12;

    // Element patterns, LSB sent first. Entry 0 = A ... entry 7 = H.
    localparam logic [7:0][ROM_W-1:0] PAT_ROM = {
        12'h055,    // H
        12'h177,    // G
        12'h175,    // F
        12'h001,    // E
        12'h057,    // D
        12'h5D7,    // C
        12'h157,    // B
        12'h01D     // A
    };

    // Number of element periods of silence between repeated frames.
    localparam int GAP_TICKS = 3;

endpackage
`default_nettype wire

// File: rtl/morse_letter_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_letter_sequencer_if
//  Description : Request/register/display bundle of the Morse sequencer.
//                master = switches/keys + shift register side,
//                slave  = the sequencer itself.
//                MORSE_REPEAT_EN adds the repeat_i request bit.
//  Revision    : 1.0  initial release
// ============================================================================
interface morse_letter_sequencer_if #(
    parameter int PAT_W = 12
);
    logic             start;
    logic [2:0]       letter;
    logic             q_lsb;
    logic [PAT_W-1:0] pattern;
    logic             load_n;
    logic             shift_en;
    logic             led;
    logic             busy;
    logic             done;
`ifdef MORSE_REPEAT_EN
    logic             repeat_i;
`endif

`ifdef MORSE_REPEAT_EN
    modport master (
        output start, letter, q_lsb, repeat_i,
        input  pattern, load_n, shift_en, led, busy, done
    );
    modport slave (
        input  start, letter, q_lsb, repeat_i,
        output pattern, load_n, shift_en, led, busy, done
    );
`else
    modport master (
        output start, letter, q_lsb,
        input  pattern, load_n, shift_en, led, busy, done
    );
    modport slave (
        input  start, letter, q_lsb,
        output pattern, load_n, shift_en, led, busy, done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/morse_letter_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tick_gen
//  Description : Element-rate divider. Counts 0..TICK_DIV-1 while run is high
//                and emits a one-cycle tick on the terminal count. clear has
//                priority and returns the count to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clear,
    input  wire logic run,
    output logic      tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap to zero on terminal count, hold when not running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == c_TERM) ? '0 : cnt_q + CW'(1);
        end
    end

    // Element counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && !clear && (cnt_q == c_TERM);

endmodule
`default_nettype wire

// File: rtl/morse_letter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_letter_sequencer
//  Description : Sequences an external rotating shift register through one
//                Morse letter (A..H) per start request: loads the ROM pattern,
//                shifts once per element period and gates the register's
//                serial bit onto the LED while shifting.
//                Optional build macro MORSE_REPEAT_EN: repeat_i input and a
//                GAP state that replays the same letter after a pause.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_letter_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_DIV = 25_000_000,
    parameter int PAT_W    = PAT_W_DEFAULT
) (
    input  wire logic                clock,
    input  wire logic                reset,
    morse_letter_sequencer_if.slave  bus
);

    localparam int BW = $clog2(PAT_W + 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(PAT_W - 1);
    localparam logic [BW-1:0] c_GAP_LAST = BW'(GAP_TICKS - 1);

    state_t        state_q;
    logic [2:0]    letter_q;
    logic [BW-1:0] bit_cnt_q;
    logic [BW-1:0] bit_cnt_d;
    logic          load_n_q;
    logic          busy_q;
    logic          done_q;

    logic          w_tick;
    logic          w_run;
    logic          w_clear;
    logic [ROM_W-1:0]       w_rom;
    logic [PAT_W+ROM_W-1:0] w_rom_ext;

    // The divider runs only while elements (or gap periods) are being timed;
    // it restarts at zero for each frame and each gap.
    assign w_run   = (state_q == S_SHIFT) || (state_q == S_GAP);
    assign w_clear = (state_q == S_LOAD)  || (state_q == S_DONE);

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .run   (w_run),
        .tick  (w_tick)
    );

    assign bit_cnt_d = bit_cnt_q + BW'(1);

    // Main sequencer FSM with registered load strobe, busy flag and done pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            letter_q  <= 3'd0;
            bit_cnt_q <= '0;
            load_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            load_n_q <= 1'b1;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        letter_q  <= bus.letter;
                        bit_cnt_q <= '0;
                        load_n_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bit_cnt_q <= '0;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == c_LAST_BIT) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    bit_cnt_q <= '0;
`ifdef MORSE_REPEAT_EN
                    if (bus.repeat_i) begin
                        state_q <= S_GAP;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
`else
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
`endif
                end
                S_GAP: begin
                    // Bit counter doubles as the gap-period counter here.
                    if (w_tick) begin
                        bit_cnt_q <= bit_cnt_d;
                        if (bit_cnt_q == c_GAP_LAST) begin
                            load_n_q <= 1'b0;
                            state_q  <= S_LOAD;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Pattern is a combinational ROM read of the latched letter, zero-extended
    // or truncated to the register width.
    assign w_rom       = PAT_ROM[letter_q];
    assign w_rom_ext   = {{PAT_W{1'b0}}, w_rom};
    assign bus.pattern = w_rom_ext[PAT_W-1:0];

    assign bus.load_n   = load_n_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.shift_en = w_tick && (state_q == S_SHIFT);
    assign bus.led      = bus.q_lsb && (state_q == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_letter_sequencer
//  Description : Scoreboard bench for morse_letter_sequencer with a model
//                rotating register. Stimulus queues expected frames; a
//                monitor checks each frame when done is presented.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_letter_sequencer;

    localparam int TICK_DIV = 4;
    localparam int PAT_W    = 12;
    localparam int FRAME    = PAT_W * TICK_DIV + 2;

    typedef struct {
        logic [11:0] pat;
        int          start_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   done_seen;
    exp_t exp_q[$];

    logic [11:0] mreg;

    morse_letter_sequencer_if #(.PAT_W(PAT_W)) bus ();

    morse_letter_sequencer #(
        .TICK_DIV (TICK_DIV),
        .PAT_W    (PAT_W)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model of the external rotating register (not cleared by reset).
    always @(posedge clk) begin
        if (!bus.load_n)      mreg <= bus.pattern;
        else if (bus.shift_en) mreg <= {mreg[0], mreg[11:1]};
    end
    assign bus.q_lsb = mreg[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: collect per-frame observations, compare on done.
    logic [11:0] m_pat;
    logic [11:0] m_ledw;
    int          m_shifts;
    int          m_busy;
    int          m_ledhi;
    int          m_last;
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.load_n) begin
                m_pat    = bus.pattern;
                m_ledw   = '0;
                m_shifts = 0;
                m_busy   = 0;
                m_ledhi  = 0;
                m_last   = cyc;
            end
            if (bus.busy) m_busy++;
            if (bus.led)  m_ledhi++;
            if (bus.shift_en) begin
                chk("shift_spacing", cyc - m_last, TICK_DIV);
                if (m_shifts < 12) m_ledw[m_shifts] = bus.led;
                m_shifts++;
                m_last = cyc;
            end
            if (bus.done) begin
                exp_t e;
                done_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_pattern",  m_pat, e.pat);
                    chk("hold_pattern",  bus.pattern, e.pat);
                    chk("led_word",      m_ledw, e.pat);
                    chk("led_hi_cycles", m_ledhi, $countones(e.pat) * TICK_DIV);
                    chk("shift_count",   m_shifts, PAT_W);
                    chk("busy_cycles",   m_busy, FRAME);
                    chk("done_latency",  cyc - e.start_cyc, FRAME);
                end
            end
        end
    end

    task automatic issue(input logic [2:0] l, input logic [11:0] pat, input bit expect_frame);
        @(negedge clk);
        bus.letter = l;
        bus.start  = 1'b1;
        if (expect_frame) exp_q.push_back('{pat: pat, start_cyc: cyc});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.letter = ~l;
    endtask

    task automatic wait_done(input int target);
        int k;
        k = 0;
        while (done_seen < target && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_wait", done_seen, target);
    endtask

    logic [2:0]  let_tab [5] = '{3'd3, 3'd5, 3'd6, 3'd7, 3'd1};
    logic [11:0] pat_tab [5] = '{12'h057, 12'h175, 12'h177, 12'h055, 12'h157};

    initial begin
        int d0;
        int k;
        cyc = 0; total = 0; bad = 0; done_seen = 0; mreg = '0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.letter = 3'd0;
`ifdef MORSE_REPEAT_EN
        bus.repeat_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset: no load strobe, all outputs at reset values.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_outs", {bus.load_n, bus.shift_en, bus.busy, bus.done, bus.led}, 5'b10000);
        end

        // A then E.
        issue(3'd0, 12'h01D, 1'b1);
        wait_done(1);
        @(negedge clk);
        chk("idle_after_done", {bus.busy, bus.led}, 2'b00);
        issue(3'd4, 12'h001, 1'b1);
        wait_done(2);

        // B with a second start (H) mid-frame: must be ignored.
        issue(3'd1, 12'h157, 1'b1);
        repeat (20) @(negedge clk);
        bus.letter = 3'd7;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("pattern_kept", bus.pattern, 12'h157);
        wait_done(3);
        repeat (10) @(negedge clk);
        chk("single_done", done_seen, 3);

        // C aborted by reset part-way through.
        d0 = done_seen;
        issue(3'd2, 12'h5D7, 1'b0);
        repeat (18) @(negedge clk);
        chk("c_busy_before_reset", bus.busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outs", {bus.load_n, bus.shift_en, bus.busy, bus.done, bus.led}, 5'b10000);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("no_done_after_reset", done_seen, d0);
        chk("idle_after_reset", bus.busy, 1'b0);

        // Full C frame, then the remaining letters.
        issue(3'd2, 12'h5D7, 1'b1);
        wait_done(d0 + 1);
        for (int i = 0; i < 5; i++) begin
            issue(let_tab[i], pat_tab[i], 1'b1);
            wait_done(d0 + 2 + i);
        end

`ifdef MORSE_REPEAT_EN
        // G repeated once via the gap, then repeat dropped.
        d0 = done_seen;
        bus.repeat_i = 1'b1;
        @(negedge clk);
        bus.letter = 3'd6;
        bus.start  = 1'b1;
        exp_q.push_back('{pat: 12'h177, start_cyc: cyc});
        exp_q.push_back('{pat: 12'h177, start_cyc: cyc + FRAME + 3 * TICK_DIV});
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("first_done_seen", bus.done, 1'b1);
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            @(negedge clk);
            chk("gap_outs", {bus.load_n, bus.shift_en, bus.busy, bus.led}, 4'b1010);
        end
        @(negedge clk);
        chk("gap_reload", {bus.load_n, bus.pattern}, {1'b0, 12'h177});
        repeat (10) @(negedge clk);
        bus.repeat_i = 1'b0;
        wait_done(d0 + 2);
        repeat (3) @(negedge clk);
        chk("idle_after_repeat", bus.busy, 1'b0);
        chk("repeat_done_count", done_seen, d0 + 2);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
